// File: rtl/gate_prefix_cache_if.sv
// Handshake and bus bundle for gate_prefix_cache.
// The cache is the master: it accepts sequence items and issues lookup and multiply requests.
// The slave view belongs to whatever surrounds the cache.
interface gate_prefix_cache_if #(
  parameter int unsigned SEQ_INDEX_BITS = 5,
  parameter int unsigned GATE_BITS      = 5,
  parameter int unsigned NUMERIC_BITS   = 37
) ();
  localparam int unsigned M = 8 * NUMERIC_BITS;

  logic                      seq_valid;
  logic [SEQ_INDEX_BITS-1:0] seq_index;
  logic [GATE_BITS-1:0]      seq_gate;
  logic                      seq_first;
  logic                      seq_ready;
  logic                      flush;
  logic                      gate_req;
  logic [GATE_BITS-1:0]      gate_sel;
  logic                      gate_ack;
  logic [M-1:0]              gate_mtx;
  logic                      mul_start;
  logic [M-1:0]              mul_a;
  logic [M-1:0]              mul_b;
  logic                      mul_done;
  logic [M-1:0]              mul_result;
  logic [M-1:0]              result_mtx;
  logic                      result_valid;
  logic [1:0]                err;
  logic [15:0]               hit_count;

  modport master (
    input  seq_valid, seq_index, seq_gate, seq_first, flush,
    input  gate_ack, gate_mtx, mul_done, mul_result,
    output seq_ready, gate_req, gate_sel, mul_start, mul_a, mul_b,
    output result_mtx, result_valid, err, hit_count
  );

  modport slave (
    output seq_valid, seq_index, seq_gate, seq_first, flush,
    output gate_ack, gate_mtx, mul_done, mul_result,
    input  seq_ready, gate_req, gate_sel, mul_start, mul_a, mul_b,
    input  result_mtx, result_valid, err, hit_count
  );
endinterface

// File: rtl/gate_prefix_cache.sv
// Tagged cache of prefix products: entry i = entry i+1 x G(gate[i]).
// An entry is recomputed only on a miss; a write invalidates every lower entry.
module gate_prefix_cache #(
  parameter int unsigned SEQ_INDEX_BITS = 5,
  parameter int unsigned GATE_BITS      = 5,
  parameter int unsigned NUMERIC_BITS   = 37,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  gate_prefix_cache_if.master  bus
);
  localparam int unsigned M     = 8 * NUMERIC_BITS;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW    = SEQ_INDEX_BITS + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_MUL} state_t;

  state_t               state_q;
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     efirst_q;
  logic [GATE_BITS-1:0] tag_q [DEPTH];
  logic [M-1:0]         mtx_q [DEPTH];

  logic [M-1:0]         greg_q;
  logic                 greg_valid_q;
  logic [GATE_BITS-1:0] greg_code_q;

  logic [IDX_W-1:0]     lidx_q;
  logic [GATE_BITS-1:0] lgate_q;
  logic                 lfirst_q;

  logic                 gate_req_q;
  logic [GATE_BITS-1:0] gate_sel_q;
  logic                 mul_start_q;
  logic [M-1:0]         mul_a_q;
  logic [M-1:0]         mul_b_q;
  logic                 result_valid_q;
  logic [1:0]           err_q;
  logic [15:0]          hit_count_q;

  logic                 accept_c;
  logic [XW-1:0]        idx_x_c;
  logic [XW-1:0]        idx_p1_c;
  logic [IDX_W-1:0]     in_idx_c;
  logic [IDX_W-1:0]     dep_idx_c;
  logic                 err_range_c;
  logic                 err_chain_c;
  logic                 hit_c;
  logic                 greg_hit_c;

  logic                 wr_en_c;
  logic [IDX_W-1:0]     wr_idx_c;
  logic [M-1:0]         wr_mtx_c;
  logic [GATE_BITS-1:0] wr_tag_c;
  logic                 wr_first_c;

  assign bus.seq_ready = (state_q == ST_IDLE) && !bus.flush && !reset;
  assign accept_c      = bus.seq_valid && bus.seq_ready;

  // Classify the offered item against the cache and the gate register.
  always_comb begin
    idx_x_c     = {1'b0, bus.seq_index};
    idx_p1_c    = idx_x_c + XW'(1);
    in_idx_c    = IDX_W'(bus.seq_index);
    dep_idx_c   = IDX_W'(idx_p1_c);
    err_range_c = (idx_x_c >= DEPTH_X);
    err_chain_c = !bus.seq_first && ((idx_p1_c >= DEPTH_X) || !valid_q[dep_idx_c]);
    hit_c       = valid_q[in_idx_c] && (tag_q[in_idx_c] == bus.seq_gate) &&
                  (efirst_q[in_idx_c] == bus.seq_first);
    greg_hit_c  = greg_valid_q && (greg_code_q == bus.seq_gate);
  end

  // Select the single entry write source for this cycle; flush suppresses any write.
  always_comb begin
    wr_en_c    = 1'b0;
    wr_idx_c   = lidx_q;
    wr_mtx_c   = greg_q;
    wr_tag_c   = lgate_q;
    wr_first_c = lfirst_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && !err_range_c && !err_chain_c && !hit_c && greg_hit_c && bus.seq_first) begin
          wr_en_c    = 1'b1;
          wr_idx_c   = in_idx_c;
          wr_mtx_c   = greg_q;
          wr_tag_c   = bus.seq_gate;
          wr_first_c = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!bus.flush && bus.gate_ack && lfirst_q) begin
          wr_en_c  = 1'b1;
          wr_mtx_c = bus.gate_mtx;
        end
      end
      ST_MUL: begin
        if (!bus.flush && bus.mul_done) begin
          wr_en_c  = 1'b1;
          wr_mtx_c = bus.mul_result;
        end
      end
      default: ;
    endcase
  end

  // Cache entries: write sets the entry and invalidates all entries below it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      efirst_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        mtx_q[i] <= '0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (wr_en_c) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) < wr_idx_c) valid_q[j] <= 1'b0;
      end
      valid_q[wr_idx_c]  <= 1'b1;
      efirst_q[wr_idx_c] <= wr_first_c;
      tag_q[wr_idx_c]    <= wr_tag_c;
      mtx_q[wr_idx_c]    <= wr_mtx_c;
    end
  end

  // Control FSM, gate register, request pulses and hit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      greg_q         <= '0;
      greg_valid_q   <= 1'b0;
      greg_code_q    <= '0;
      lidx_q         <= '0;
      lgate_q        <= '0;
      lfirst_q       <= 1'b0;
      gate_req_q     <= 1'b0;
      gate_sel_q     <= '0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 2'b00;
      hit_count_q    <= 16'd0;
    end else begin
      gate_req_q     <= 1'b0;
      mul_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 2'b00;
      if (bus.flush) begin
        state_q      <= ST_IDLE;
        greg_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_c) begin
              lidx_q   <= in_idx_c;
              lgate_q  <= bus.seq_gate;
              lfirst_q <= bus.seq_first;
              if (err_range_c) begin
                err_q <= 2'b01;
              end else if (err_chain_c) begin
                err_q <= 2'b10;
              end else if (hit_c) begin
                if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
                result_valid_q <= (in_idx_c == '0);
              end else if (greg_hit_c) begin
                if (bus.seq_first) begin
                  result_valid_q <= (in_idx_c == '0);
                end else begin
                  mul_start_q <= 1'b1;
                  mul_a_q     <= mtx_q[dep_idx_c];
                  mul_b_q     <= greg_q;
                  state_q     <= ST_MUL;
                end
              end else begin
                gate_req_q <= 1'b1;
                gate_sel_q <= bus.seq_gate;
                state_q    <= ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            if (bus.gate_ack) begin
              greg_q       <= bus.gate_mtx;
              greg_valid_q <= 1'b1;
              greg_code_q  <= lgate_q;
              if (lfirst_q) begin
                result_valid_q <= (lidx_q == '0);
                state_q        <= ST_IDLE;
              end else begin
                mul_start_q <= 1'b1;
                mul_a_q     <= mtx_q[lidx_q + IDX_W'(1)];
                mul_b_q     <= bus.gate_mtx;
                state_q     <= ST_MUL;
              end
            end
          end
          ST_MUL: begin
            if (bus.mul_done) begin
              result_valid_q <= (lidx_q == '0);
              state_q        <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.gate_req     = gate_req_q;
  assign bus.gate_sel     = gate_sel_q;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.result_mtx   = mtx_q[0];
  assign bus.result_valid = result_valid_q;
  assign bus.err          = err_q;
  assign bus.hit_count    = hit_count_q;
endmodule

// File: tb/tb_gate_prefix_cache.sv
// Bench for gate_prefix_cache: directed and random items against a behavioural cache model.
module tb_gate_prefix_cache;
  localparam int unsigned SIB   = 5;
  localparam int unsigned GB    = 5;
  localparam int unsigned NB    = 37;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned M     = 8 * NB;
  typedef logic [M-1:0] mtx_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gate_prefix_cache_if #(.SEQ_INDEX_BITS(SIB), .GATE_BITS(GB), .NUMERIC_BITS(NB)) bus ();

  gate_prefix_cache #(.SEQ_INDEX_BITS(SIB), .GATE_BITS(GB), .NUMERIC_BITS(NB), .DEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Complex 2x2 matrix helpers on the flat bus layout.
  function automatic longint comp(input mtx_t m, input int r, input int c, input int k);
    logic signed [NB-1:0] v;
    v = m[((r * 2 + c) * 2 + k) * NB +: NB];
    return longint'(v);
  endfunction

  function automatic mtx_t setc(input mtx_t m, input int r, input int c, input int k, input longint val);
    mtx_t o;
    o = m;
    o[((r * 2 + c) * 2 + k) * NB +: NB] = NB'(val);
    return o;
  endfunction

  function automatic mtx_t gmat(input int code);
    mtx_t m;
    m = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 2; k++)
          m = setc(m, r, c, k, longint'((code * 7 + r * 5 + c * 3 + k * 2 + 1) % 5) - 64'sd2);
    return m;
  endfunction

  function automatic mtx_t cmul(input mtx_t a, input mtx_t b);
    mtx_t o;
    longint re, im;
    o = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        re = 0;
        im = 0;
        for (int j = 0; j < 2; j++) begin
          re += comp(a, r, j, 0) * comp(b, j, c, 0) - comp(a, r, j, 1) * comp(b, j, c, 1);
          im += comp(a, r, j, 0) * comp(b, j, c, 1) + comp(a, r, j, 1) * comp(b, j, c, 0);
        end
        o = setc(o, r, c, 0, re);
        o = setc(o, r, c, 1, im);
      end
    return o;
  endfunction

  // Lookup and multiplier stubs with adjustable latency.
  int gate_lat = 0;
  int mul_lat  = 0;

  initial begin : gate_stub
    int code;
    bus.gate_ack = 1'b0;
    bus.gate_mtx = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.gate_req) begin
        code = int'(bus.gate_sel);
        repeat (gate_lat + 1) @(negedge clk);
        bus.gate_ack = 1'b1;
        bus.gate_mtx = gmat(code);
        @(negedge clk);
        bus.gate_ack = 1'b0;
        bus.gate_mtx = '0;
      end
    end
  end

  initial begin : mul_stub
    mtx_t a_cap, b_cap;
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.mul_start) begin
        a_cap = bus.mul_a;
        b_cap = bus.mul_b;
        for (int s = 0; s <= mul_lat; s++) begin
          @(negedge clk);
          check("mul_a_stable", bus.mul_a, a_cap);
          check("mul_b_stable", bus.mul_b, b_cap);
        end
        bus.mul_done   = 1'b1;
        bus.mul_result = cmul(a_cap, b_cap);
        @(negedge clk);
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
      end
    end
  end

  // Pulse counters sampled mid-cycle.
  int mon_req = 0, mon_mul = 0, mon_rv = 0, mon_err = 0;
  logic [1:0] mon_err_val = 2'b00;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.gate_req)     mon_req++;
      if (bus.mul_start)    mon_mul++;
      if (bus.result_valid) mon_rv++;
      if (bus.err != 2'b00) begin
        mon_err++;
        mon_err_val = bus.err;
      end
    end
  end

  // Behavioural cache model.
  bit   m_valid [DEPTH];
  int   m_tag   [DEPTH];
  bit   m_first [DEPTH];
  mtx_t m_mtx   [DEPTH];
  bit   m_greg_v;
  int   m_greg_code;
  int   m_hits;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_first[i] = 0; m_mtx[i] = '0;
    end
    m_greg_v = 0; m_greg_code = 0; m_hits = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_greg_v = 0;
  endtask

  task automatic model_step(input int idx, input int gate, input bit first,
                            output int e_err, output int e_req, output int e_mul, output int e_rv);
    e_err = 0; e_req = 0; e_mul = 0; e_rv = 0;
    if (idx >= DEPTH) e_err = 1;
    else if (!first && (idx + 1 >= DEPTH || !m_valid[idx + 1])) e_err = 2;
    else if (m_valid[idx] && m_tag[idx] == gate && m_first[idx] == first) begin
      if (m_hits < 65535) m_hits++;
      e_rv = (idx == 0);
    end else begin
      if (!(m_greg_v && m_greg_code == gate)) begin
        e_req = 1; m_greg_v = 1; m_greg_code = gate;
      end
      e_mul = first ? 0 : 1;
      m_mtx[idx] = first ? gmat(gate) : cmul(m_mtx[idx + 1], gmat(gate));
      m_valid[idx] = 1; m_tag[idx] = gate; m_first[idx] = first;
      for (int j = 0; j < idx; j++) m_valid[j] = 0;
      e_rv = (idx == 0);
    end
  endtask

  task automatic send_item(input int idx, input int gate, input bit first);
    int e_err, e_req, e_mul, e_rv;
    int r0, m0, v0, x0;
    bit done;
    string id;
    id = $sformatf("i%0d_g%0d_f%0d", idx, gate, first);
    model_step(idx, gate, first, e_err, e_req, e_mul, e_rv);
    r0 = mon_req; m0 = mon_mul; v0 = mon_rv; x0 = mon_err;
    @(negedge clk);
    bus.seq_valid = 1'b1;
    bus.seq_index = SIB'(idx);
    bus.seq_gate  = GB'(gate);
    bus.seq_first = first;
    @(negedge clk);
    bus.seq_valid = 1'b0;
    done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (bus.seq_ready) done = 1;
      else @(negedge clk);
    end
    #1;
    check({"done_", id}, done, 1);
    check({"gate_req_", id}, mon_req - r0, e_req);
    check({"mul_start_", id}, mon_mul - m0, e_mul);
    check({"result_valid_", id}, mon_rv - v0, e_rv);
    check({"err_pulse_", id}, mon_err - x0, (e_err != 0));
    if (e_err != 0) check({"err_code_", id}, mon_err_val, e_err);
    check({"hit_count_", id}, bus.hit_count, m_hits);
    check({"result_mtx_", id}, bus.result_mtx, m_mtx[0]);
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    #1 check("ready_during_flush", bus.seq_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    model_flush();
  endtask

  task automatic base_sequence();
    send_item(4, 3, 1);
    send_item(3, 1, 0);
    send_item(2, 1, 0);
    send_item(1, 1, 0);
    send_item(0, 1, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog expired n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, m0, v0, e0, h0, cur;
    mtx_t ref_prod, zero_lat_res;
    bus.seq_valid = 1'b0;
    bus.seq_index = '0;
    bus.seq_gate  = '0;
    bus.seq_first = 1'b0;
    bus.flush     = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("ready_in_reset", bus.seq_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.seq_ready, 1);
    check("hit_count_reset", bus.hit_count, 0);
    check("result_mtx_reset", bus.result_mtx, '0);
    check("mul_a_reset", bus.mul_a, '0);
    check("mul_b_reset", bus.mul_b, '0);
    check("pulses_reset", {bus.gate_req, bus.mul_start, bus.result_valid, bus.err}, 0);

    // Build a chain, then replay it.
    r0 = mon_req; m0 = mon_mul; v0 = mon_rv;
    base_sequence();
    check("build_lookups", mon_req - r0, 2);
    check("build_muls", mon_mul - m0, 4);
    check("build_rv", mon_rv - v0, 1);
    ref_prod = gmat(3);
    for (int i = 0; i < 4; i++) ref_prod = cmul(ref_prod, gmat(1));
    check("build_product", bus.result_mtx, ref_prod);
    zero_lat_res = bus.result_mtx;

    r0 = mon_req; m0 = mon_mul;
    base_sequence();
    check("replay_no_lookup", mon_req - r0, 0);
    check("replay_no_mul", mon_mul - m0, 0);
    check("replay_hits", bus.hit_count, 5);

    // Change only the gate at index 2.
    m0 = mon_mul;
    send_item(4, 3, 1);
    send_item(3, 1, 0);
    send_item(2, 2, 0);
    send_item(1, 1, 0);
    send_item(0, 1, 0);
    check("change_muls", mon_mul - m0, 3);

    // Error paths leave the cache intact.
    send_item(DEPTH, 1, 0);
    send_item(6, 1, 0);
    send_item(0, 1, 0);

    // Flush together with an offered item: not accepted.
    r0 = mon_req; v0 = mon_rv; e0 = mon_err; h0 = int'(bus.hit_count);
    @(negedge clk);
    bus.seq_valid = 1'b1; bus.seq_index = '0; bus.seq_gate = GB'(1); bus.seq_first = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.seq_valid = 1'b0; bus.flush = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    #1;
    check("flush_item_no_req", mon_req - r0, 0);
    check("flush_item_no_rv", mon_rv - v0, 0);
    check("flush_item_no_err", mon_err - e0, 0);
    check("flush_item_no_hit", bus.hit_count, h0);

    // Flush while a multiply is outstanding; the late mul_done is ignored.
    send_item(7, 5, 1);
    mul_lat = 2;
    m0 = mon_mul; v0 = mon_rv;
    @(negedge clk);
    bus.seq_valid = 1'b1; bus.seq_index = SIB'(6); bus.seq_gate = GB'(5); bus.seq_first = 1'b0;
    @(negedge clk);
    bus.seq_valid = 1'b0;
    check("abort_mul_started", bus.mul_start, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_flush();
    repeat (8) @(negedge clk);
    #1;
    check("abort_one_mul", mon_mul - m0, 1);
    check("abort_no_rv", mon_rv - v0, 0);
    check("abort_idle", bus.seq_ready, 1);
    check("abort_result_kept", bus.result_mtx, m_mtx[0]);
    send_item(7, 5, 1);
    send_item(6, 5, 0);
    mul_lat = 0;

    // Long stalls give the same product.
    gate_lat = 7; mul_lat = 7;
    do_flush();
    base_sequence();
    check("stall_same_result", bus.result_mtx, zero_lat_res);

    // Random items with random latencies.
    cur = DEPTH - 1;
    for (int n = 0; n < 70; n++) begin
      gate_lat = $urandom_range(0, 3);
      mul_lat  = $urandom_range(0, 3);
      if ($urandom_range(0, 14) == 0) do_flush();
      if ($urandom_range(0, 7) == 0) cur = $urandom_range(0, DEPTH);
      send_item(cur, $urandom_range(0, 2), (cur == DEPTH - 1) || ($urandom_range(0, 5) == 0));
      cur = (cur == 0 || cur >= DEPTH) ? DEPTH - 1 : cur - 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
